// File: rtl/cpu_defs.sv
// Shared CPU definitions: PCSrc encodings, exception vectors and the
// exception sequencer state type.
package cpu_defs;

  localparam logic [2:0] PCSRC_SEQ   = 3'b000;
  localparam logic [2:0] PCSRC_BR    = 3'b001;
  localparam logic [2:0] PCSRC_J     = 3'b010;
  localparam logic [2:0] PCSRC_JR    = 3'b011;
  localparam logic [2:0] PCSRC_ILLOP = 3'b100;
  localparam logic [2:0] PCSRC_XADR  = 3'b101;

  localparam logic [31:0] ILLOP_ADDR = 32'h8000_0004;
  localparam logic [31:0] XADR_ADDR  = 32'h8000_0020;

  localparam logic [3:0] CAUSE_ILLOP = 4'hF;

  typedef enum logic [1:0] {
    ST_USER      = 2'd0,
    ST_ENTER     = 2'd1,
    ST_KERNEL    = 2'd2,
    ST_GUARDWAIT = 2'd3
  } exc_state_e;

endpackage

// File: rtl/exc_ctrl_if.sv
// Handshake bundle between the CPU datapath/peripherals (master) and the
// exception sequencer (slave).
interface exc_ctrl_if #(parameter int N_IRQ = 4);

  logic             inst_valid;
  logic             pc_kernel;
  logic             illop;
  logic [N_IRQ-1:0] irq_req;
  logic [N_IRQ-1:0] irq_mask;
  logic [2:0]       dec_pcsrc;
  logic [2:0]       pcsrc;
  logic             save_epc;
  logic [N_IRQ-1:0] irq_ack;
  logic [3:0]       cause;
  logic [N_IRQ-1:0] pending;
  logic             double_fault;

  modport master (
    output inst_valid, pc_kernel, illop, irq_req, irq_mask, dec_pcsrc,
    input  pcsrc, save_epc, irq_ack, cause, pending, double_fault
  );

  modport slave (
    input  inst_valid, pc_kernel, illop, irq_req, irq_mask, dec_pcsrc,
    output pcsrc, save_epc, irq_ack, cause, pending, double_fault
  );

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over an already masked request vector.
module irq_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic         any,
  output logic [3:0]   idx,
  output logic [N-1:0] onehot
);

  // Two's complement trick keeps only the lowest set bit.
  assign onehot = req & (~req + N'(1));
  assign any    = |req;

  // Binary index of the single surviving bit.
  always_comb begin
    idx = 4'd0;
    for (int i = 0; i < N; i++) begin
      idx = idx | (onehot[i] ? 4'(i) : 4'd0);
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: overrides PCSrc with the ILLOP or XADR
// vector, requests the $k0 save and tracks user/kernel transitions.
module exc_ctrl
  import cpu_defs::*;
#(
  parameter int N_IRQ = 4,
  parameter int GUARD = 1
) (
  input  logic        clk,
  input  logic        reset,
  exc_ctrl_if.slave   bus
);

  localparam logic [2:0] GUARD_RST  = 3'(GUARD);
  localparam logic [2:0] GUARD_LOAD = (GUARD == 0) ? 3'd0 : 3'(GUARD - 1);

  exc_state_e       state_q, state_d;
  logic [N_IRQ-1:0] irq_q, irq_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [2:0]       guard_q, guard_d;
  logic [3:0]       cause_q, cause_d;
  logic             dfault_q, dfault_d;

  logic [N_IRQ-1:0] new_evt_s;
  logic             enc_any_s;
  logic [3:0]       enc_idx_s;
  logic [N_IRQ-1:0] enc_onehot_s;
  logic [2:0]       pcsrc_s;
  logic             save_s;
  logic [N_IRQ-1:0] ack_s;
  logic             illop_ok_s;
  logic             irq_ok_s;

  irq_prio_enc #(.N(N_IRQ)) u_prio (
    .req    (pending_q & ~bus.irq_mask),
    .any    (enc_any_s),
    .idx    (enc_idx_s),
    .onehot (enc_onehot_s)
  );

  // Edge capture: a new event sets pending even when masked; set beats ack.
  always_comb begin
    irq_d     = bus.irq_req;
    new_evt_s = bus.irq_req & ~irq_q;
    pending_d = new_evt_s | (pending_q & ~ack_s);
  end

  // Mode tracking plus the same-cycle take decision.
  always_comb begin
    state_d    = state_q;
    guard_d    = guard_q;
    cause_d    = cause_q;
    pcsrc_s    = bus.dec_pcsrc;
    save_s     = 1'b0;
    ack_s      = '0;
    illop_ok_s = 1'b0;
    irq_ok_s   = 1'b0;

    if (bus.inst_valid && bus.illop && (state_q == ST_KERNEL || bus.pc_kernel)) begin
      dfault_d = 1'b1;
    end else begin
      dfault_d = dfault_q;
    end

    case (state_q)
      ST_USER: begin
        if (!bus.inst_valid) begin
          state_d = state_q;
        end else if (bus.pc_kernel) begin
          state_d = ST_KERNEL;
        end else begin
          illop_ok_s = 1'b1;
          irq_ok_s   = 1'b1;
        end
      end
      ST_ENTER: begin
        state_d = ST_KERNEL;
      end
      ST_KERNEL: begin
        // First user instruction after the return jr.
        if (bus.inst_valid && !bus.pc_kernel) begin
          if (GUARD == 0) begin
            state_d    = ST_USER;
            illop_ok_s = 1'b1;
            irq_ok_s   = 1'b1;
          end else begin
            state_d = ST_GUARDWAIT;
            guard_d = GUARD_LOAD;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_GUARDWAIT: begin
        if (!bus.inst_valid) begin
          state_d = state_q;
        end else if (bus.pc_kernel) begin
          state_d = ST_KERNEL;
        end else begin
          illop_ok_s = 1'b1;
          if (guard_q == 3'd0) begin
            state_d = ST_USER;
          end else begin
            guard_d = guard_q - 3'd1;
          end
        end
      end
      default: begin
        state_d = ST_USER;
      end
    endcase

    // Illegal opcode outranks interrupts; the interrupt simply stays pending.
    if (illop_ok_s && bus.illop) begin
      pcsrc_s = PCSRC_ILLOP;
      save_s  = 1'b1;
      cause_d = CAUSE_ILLOP;
      state_d = ST_ENTER;
    end else if (irq_ok_s && enc_any_s) begin
      pcsrc_s = PCSRC_XADR;
      save_s  = 1'b1;
      ack_s   = enc_onehot_s;
      cause_d = enc_idx_s;
      state_d = ST_ENTER;
    end else begin
      pcsrc_s = bus.dec_pcsrc;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_USER;
      irq_q     <= '0;
      pending_q <= '0;
      guard_q   <= GUARD_RST;
      cause_q   <= 4'd0;
      dfault_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_d;
      pending_q <= pending_d;
      guard_q   <= guard_d;
      cause_q   <= cause_d;
      dfault_q  <= dfault_d;
    end
  end

  assign bus.pcsrc        = pcsrc_s;
  assign bus.save_epc     = save_s;
  assign bus.irq_ack      = ack_s;
  assign bus.cause        = cause_q;
  assign bus.pending      = pending_q;
  assign bus.double_fault = dfault_q;

endmodule
